// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_arb_pkg
//  Description : Shared types and constants for the two-master APB
//                round-robin arbiter (state encoding, error read value).
//  Revision    : 1.0  initial release
// ============================================================================
package apb_arb_pkg;

    // Arbiter sequencing states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Read data returned to a master whose transfer timed out.
    localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage : apb_arb_pkg
`default_nettype wire

// File: rtl/apb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_pick
//  Description : Combinational two-way round-robin pick. A lone requester
//                wins outright; on a tie the master that was not granted
//                last time wins.
//  Ports       : i_req[1:0]    request vector (bit n = master n)
//                i_last_grant  index of the previously granted master
//                o_valid       at least one request present
//                o_grant       index of the winning master
//  Revision    : 1.0  initial release
// ============================================================================
module apb_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_grant
);

    always_comb begin
        o_valid = |i_req;
        case (i_req)
            2'b01:   o_grant = 1'b0;
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_last_grant;
            default: o_grant = i_last_grant;  // no request; value unused
        endcase
    end

endmodule : apb_rr_pick
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_arbiter
//  Description : Two-master, one-slave APB arbiter. A request (Mx_PSEL in
//                IDLE) is granted round-robin, its fields are latched and
//                replayed downstream with fresh SETUP/ACCESS phases, and the
//                result is returned as a one-cycle Mx_PREADY pulse. A ready
//                timeout stops a hung slave from locking out both hosts.
//  Ports       : PCLK, PRESET (sync, active-high)
//                M0_* / M1_*  upstream APB slave ports (PSEL, PADDR, PENABLE,
//                             PWRITE, PWDATA in; PRDATA, PREADY, PSLVERR out)
//                S_*          downstream APB master port
//                GRANT        current / last granted master index
//                BUSY         arbiter not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // master 0
    input  logic              M0_PSEL,
    input  logic [ADDR_W-1:0] M0_PADDR,
    input  logic              M0_PENABLE,
    input  logic              M0_PWRITE,
    input  logic [DATA_W-1:0] M0_PWDATA,
    output logic [DATA_W-1:0] M0_PRDATA,
    output logic              M0_PREADY,
    output logic              M0_PSLVERR,
    // master 1
    input  logic              M1_PSEL,
    input  logic [ADDR_W-1:0] M1_PADDR,
    input  logic              M1_PENABLE,
    input  logic              M1_PWRITE,
    input  logic [DATA_W-1:0] M1_PWDATA,
    output logic [DATA_W-1:0] M1_PRDATA,
    output logic              M1_PREADY,
    output logic              M1_PSLVERR,
    // downstream slave
    output logic              S_PSEL,
    output logic [ADDR_W-1:0] S_PADDR,
    output logic              S_PENABLE,
    output logic              S_PWRITE,
    output logic [DATA_W-1:0] S_PWDATA,
    input  logic [DATA_W-1:0] S_PRDATA,
    input  logic              S_PREADY,
    // status
    output logic              GRANT,
    output logic              BUSY
);

    // Counter is wide enough to hold TIMEOUT itself; keep at least one bit
    // so a disabled timeout still elaborates.
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_TO_CNT = CNT_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last_grant;
    logic                r_drop;        // granted master released PSEL mid-transfer

    logic                r_s_psel;
    logic                r_s_penable;
    logic [ADDR_W-1:0]   r_s_paddr;
    logic                r_s_pwrite;
    logic [DATA_W-1:0]   r_s_pwdata;
    logic [DATA_W-1:0]   r_m0_prdata;
    logic                r_m0_pready;
    logic                r_m0_pslverr;
    logic [DATA_W-1:0]   r_m1_prdata;
    logic                r_m1_pready;
    logic                r_m1_pslverr;
    logic                r_grant;
    logic                r_busy;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    state_t              w_state_next;
    logic                w_pick_valid;
    logic                w_pick_grant;
    logic                w_gnt_psel;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;
    logic                w_access_end;
    logic                w_abandon;
    logic                w_resp_fire;
    logic [DATA_W-1:0]   w_cap_data;
    logic                w_cap_err;

    logic                w_s_psel;
    logic                w_s_penable;
    logic [ADDR_W-1:0]   w_s_paddr;
    logic                w_s_pwrite;
    logic [DATA_W-1:0]   w_s_pwdata;
    logic [DATA_W-1:0]   w_m0_prdata;
    logic                w_m0_pready;
    logic                w_m0_pslverr;
    logic [DATA_W-1:0]   w_m1_prdata;
    logic                w_m1_pready;
    logic                w_m1_pslverr;
    logic                w_grant;
    logic                w_last_grant;
    logic                w_busy;

    // PENABLE from the masters plays no part in arbitration or sequencing.
    logic                w_unused_penable;
    assign w_unused_penable = &{1'b0, M0_PENABLE, M1_PENABLE};

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    apb_rr_pick u_pick (
        .i_req        ({M1_PSEL, M0_PSEL}),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_grant      (w_pick_grant)
    );

    assign w_gnt_psel   = r_grant ? M1_PSEL : M0_PSEL;
    assign w_cnt_inc    = r_cnt + 1'b1;
    // Fires on the edge that closes the TIMEOUT-th ACCESS cycle.
    assign w_timeout    = (TIMEOUT != 0) && (r_state == ACCESS) && !S_PREADY
                          && (w_cnt_inc == c_TO_CNT);
    assign w_access_end = (r_state == ACCESS) && (S_PREADY || w_timeout);
    // A master that let go of PSEL at any point gets no completion pulse.
    assign w_abandon    = r_drop || !w_gnt_psel;
    assign w_resp_fire  = w_access_end && !w_abandon;
    assign w_cap_data   = S_PREADY ? S_PRDATA : DATA_W'(ERR_RDATA);
    assign w_cap_err    = !S_PREADY;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_next = SETUP;
            SETUP:   w_state_next = ACCESS;
            ACCESS:  if (S_PREADY || w_timeout) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Computes the next value of every registered
    // output from the upcoming state so outputs line up with it.
    // ------------------------------------------------------------------
    always_comb begin
        w_s_psel     = (w_state_next == SETUP) || (w_state_next == ACCESS);
        w_s_penable  = (w_state_next == ACCESS);
        w_busy       = (w_state_next != IDLE);
        w_s_paddr    = r_s_paddr;
        w_s_pwrite   = r_s_pwrite;
        w_s_pwdata   = r_s_pwdata;
        w_grant      = r_grant;
        w_last_grant = r_last_grant;
        w_m0_prdata  = r_m0_prdata;
        w_m0_pslverr = r_m0_pslverr;
        w_m0_pready  = 1'b0;
        w_m1_prdata  = r_m1_prdata;
        w_m1_pslverr = r_m1_pslverr;
        w_m1_pready  = 1'b0;

        if ((r_state == IDLE) && w_pick_valid) begin
            w_grant      = w_pick_grant;
            w_last_grant = w_pick_grant;
            if (w_pick_grant) begin
                w_s_paddr  = M1_PADDR;
                w_s_pwrite = M1_PWRITE;
                w_s_pwdata = M1_PWDATA;
            end else begin
                w_s_paddr  = M0_PADDR;
                w_s_pwrite = M0_PWRITE;
                w_s_pwdata = M0_PWDATA;
            end
        end

        if (w_resp_fire) begin
            if (r_grant) begin
                w_m1_pready  = 1'b1;
                w_m1_prdata  = w_cap_data;
                w_m1_pslverr = w_cap_err;
            end else begin
                w_m0_pready  = 1'b1;
                w_m0_prdata  = w_cap_data;
                w_m0_pslverr = w_cap_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_s_psel     <= 1'b0;
            r_s_penable  <= 1'b0;
            r_s_paddr    <= '0;
            r_s_pwrite   <= 1'b0;
            r_s_pwdata   <= '0;
            r_m0_prdata  <= '0;
            r_m0_pready  <= 1'b0;
            r_m0_pslverr <= 1'b0;
            r_m1_prdata  <= '0;
            r_m1_pready  <= 1'b0;
            r_m1_pslverr <= 1'b0;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_last_grant <= 1'b1;   // M0 wins the first tie
        end else begin
            r_s_psel     <= w_s_psel;
            r_s_penable  <= w_s_penable;
            r_s_paddr    <= w_s_paddr;
            r_s_pwrite   <= w_s_pwrite;
            r_s_pwdata   <= w_s_pwdata;
            r_m0_prdata  <= w_m0_prdata;
            r_m0_pready  <= w_m0_pready;
            r_m0_pslverr <= w_m0_pslverr;
            r_m1_prdata  <= w_m1_prdata;
            r_m1_pready  <= w_m1_pready;
            r_m1_pslverr <= w_m1_pslverr;
            r_grant      <= w_grant;
            r_busy       <= w_busy;
            r_last_grant <= w_last_grant;
        end
    end

    // ACCESS-cycle counter, saturating at TIMEOUT, cleared outside ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt <= '0;
        end else if (r_state == ACCESS) begin
            if (r_cnt != c_TO_CNT) begin
                r_cnt <= w_cnt_inc;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Sticky record that the granted master dropped PSEL during the transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_drop <= 1'b0;
        end else if (r_state == IDLE) begin
            r_drop <= 1'b0;
        end else if (((r_state == SETUP) || (r_state == ACCESS)) && !w_gnt_psel) begin
            r_drop <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign S_PSEL     = r_s_psel;
    assign S_PENABLE  = r_s_penable;
    assign S_PADDR    = r_s_paddr;
    assign S_PWRITE   = r_s_pwrite;
    assign S_PWDATA   = r_s_pwdata;
    assign M0_PRDATA  = r_m0_prdata;
    assign M0_PREADY  = r_m0_pready;
    assign M0_PSLVERR = r_m0_pslverr;
    assign M1_PRDATA  = r_m1_prdata;
    assign M1_PREADY  = r_m1_pready;
    assign M1_PSLVERR = r_m1_pslverr;
    assign GRANT      = r_grant;
    assign BUSY       = r_busy;

endmodule : apb_rr_arbiter
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_apb_rr_arbiter
//  Description : Directed self-checking bench for apb_rr_arbiter. Inputs
//                change and outputs are sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_rr_arbiter;

    logic       PCLK;
    logic       PRESET;
    logic       M0_PSEL, M0_PENABLE, M0_PWRITE;
    logic [7:0] M0_PADDR, M0_PWDATA, M0_PRDATA;
    logic       M0_PREADY, M0_PSLVERR;
    logic       M1_PSEL, M1_PENABLE, M1_PWRITE;
    logic [7:0] M1_PADDR, M1_PWDATA, M1_PRDATA;
    logic       M1_PREADY, M1_PSLVERR;
    logic       S_PSEL, S_PENABLE, S_PWRITE;
    logic [7:0] S_PADDR, S_PWDATA, S_PRDATA;
    logic       S_PREADY;
    logic       GRANT, BUSY;

    int         n_vec;
    int         n_err;
    int         wait_states;
    logic [7:0] slv_rdata;

    apb_rr_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .M0_PSEL    (M0_PSEL),
        .M0_PADDR   (M0_PADDR),
        .M0_PENABLE (M0_PENABLE),
        .M0_PWRITE  (M0_PWRITE),
        .M0_PWDATA  (M0_PWDATA),
        .M0_PRDATA  (M0_PRDATA),
        .M0_PREADY  (M0_PREADY),
        .M0_PSLVERR (M0_PSLVERR),
        .M1_PSEL    (M1_PSEL),
        .M1_PADDR   (M1_PADDR),
        .M1_PENABLE (M1_PENABLE),
        .M1_PWRITE  (M1_PWRITE),
        .M1_PWDATA  (M1_PWDATA),
        .M1_PRDATA  (M1_PRDATA),
        .M1_PREADY  (M1_PREADY),
        .M1_PSLVERR (M1_PSLVERR),
        .S_PSEL     (S_PSEL),
        .S_PADDR    (S_PADDR),
        .S_PENABLE  (S_PENABLE),
        .S_PWRITE   (S_PWRITE),
        .S_PWDATA   (S_PWDATA),
        .S_PRDATA   (S_PRDATA),
        .S_PREADY   (S_PREADY),
        .GRANT      (GRANT),
        .BUSY       (BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model: asserts S_PREADY after wait_states ACCESS cycles.
    initial begin : slave_model
        int acc;
        acc      = 0;
        S_PREADY = 1'b0;
        S_PRDATA = 8'h00;
        forever begin
            @(negedge PCLK);
            if (S_PSEL && S_PENABLE) begin
                S_PREADY = (acc >= wait_states);
                acc++;
            end else begin
                acc      = 0;
                S_PREADY = 1'b0;
            end
            S_PRDATA = slv_rdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-master transfer; lat = cycle (after the sampling edge) in which
    // PREADY is expected, so SETUP/ACCESS occupy cycles 1..lat-1.
    task automatic xfer(input string tag, input logic m, input logic [7:0] addr,
                        input logic wr, input logic [7:0] wd, input int lat,
                        input logic [7:0] exp_rd, input logic exp_err);
        if (m) begin
            M1_PSEL = 1'b1; M1_PADDR = addr; M1_PWRITE = wr; M1_PWDATA = wd;
        end else begin
            M0_PSEL = 1'b1; M0_PADDR = addr; M0_PWRITE = wr; M0_PWDATA = wd;
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge PCLK);
            check({tag, "_psel"}, S_PSEL, c < lat);
            check({tag, "_penable"}, S_PENABLE, (c > 1) && (c < lat));
            check({tag, "_pready"}, m ? M1_PREADY : M0_PREADY, c == lat);
            check({tag, "_other_pready"}, m ? M0_PREADY : M1_PREADY, 1'b0);
            if (c < lat)
                check({tag, "_sbus"}, {S_PWRITE, S_PADDR, S_PWDATA}, {wr, addr, wd});
        end
        check({tag, "_prdata"}, m ? M1_PRDATA : M0_PRDATA, exp_rd);
        check({tag, "_pslverr"}, m ? M1_PSLVERR : M0_PSLVERR, exp_err);
        check({tag, "_grant"}, GRANT, m);
        check({tag, "_busy_resp"}, BUSY, 1'b1);
        if (m) M1_PSEL = 1'b0; else M0_PSEL = 1'b0;
        @(negedge PCLK);
        check({tag, "_busy_idle"}, BUSY, 1'b0);
        check({tag, "_pready_low"}, m ? M1_PREADY : M0_PREADY, 1'b0);
    endtask

    initial begin : stim
        logic [3:0] order;
        int n0, n1;
        n_vec = 0; n_err = 0;
        wait_states = 0; slv_rdata = 8'h00;
        PRESET = 1'b1;
        M0_PSEL = 0; M0_PENABLE = 0; M0_PWRITE = 0; M0_PADDR = 0; M0_PWDATA = 0;
        M1_PSEL = 0; M1_PENABLE = 0; M1_PWRITE = 0; M1_PADDR = 0; M1_PWDATA = 0;

        // Reset state
        repeat (3) @(negedge PCLK);
        check("reset_all_zero",
              {S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA, M0_PRDATA, M0_PREADY,
               M0_PSLVERR, M1_PRDATA, M1_PREADY, M1_PSLVERR, GRANT, BUSY}, 64'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("idle_busy", BUSY, 1'b0);

        // M0 zero-wait read
        wait_states = 0; slv_rdata = 8'h42;
        xfer("t1_m0_read", 1'b0, 8'hF8, 1'b0, 8'h00, 3, 8'h42, 1'b0);

        // M1 write with 3 wait states (write captures slave data too)
        wait_states = 3; slv_rdata = 8'h5A;
        xfer("t3_m1_write", 1'b1, 8'h01, 1'b1, 8'hA5, 6, 8'h5A, 1'b0);

        // Hung slave: 16 ACCESS cycles then error response
        wait_states = 255; slv_rdata = 8'h11;
        xfer("t4_timeout", 1'b0, 8'h10, 1'b0, 8'h00, 18, 8'hFF, 1'b1);
        wait_states = 0; slv_rdata = 8'h3C;
        xfer("t4_after", 1'b0, 8'h22, 1'b0, 8'h00, 3, 8'h3C, 1'b0);

        // M0 drops PSEL during ACCESS while M1 is pending
        wait_states = 1; slv_rdata = 8'h77;
        M0_PSEL = 1'b1; M0_PADDR = 8'h30; M0_PWRITE = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge PCLK);
            check("t6_m0_pready", M0_PREADY, 1'b0);
            check("t6_psel", S_PSEL, (c <= 3) || ((c >= 6) && (c <= 8)));
            check("t6_penable", S_PENABLE, (c == 2) || (c == 3) || (c == 7) || (c == 8));
            check("t6_m1_pready", M1_PREADY, c == 9);
            check("t6_busy", BUSY, c != 5);
            check("t6_grant", GRANT, c >= 6);
            if (c == 1) begin
                M1_PSEL = 1'b1; M1_PADDR = 8'h40; M1_PWRITE = 1'b0;
            end
            if (c == 2) M0_PSEL = 1'b0;
        end
        check("t6_m1_prdata", M1_PRDATA, 8'h77);
        M1_PSEL = 1'b0;
        @(negedge PCLK);

        // Reset during ACCESS of an M0 transfer (last grant becomes M0)
        wait_states = 3; slv_rdata = 8'h99;
        M0_PSEL = 1'b1; M0_PADDR = 8'h50;
        @(negedge PCLK);
        check("t5_setup_grant", {S_PSEL, GRANT}, 2'b10);
        @(negedge PCLK);
        check("t5_access", {S_PSEL, S_PENABLE}, 2'b11);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("t5_reset_all_zero",
              {S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA, M0_PRDATA, M0_PREADY,
               M0_PSLVERR, M1_PRDATA, M1_PREADY, M1_PSLVERR, GRANT, BUSY}, 64'd0);
        PRESET = 1'b0;
        wait_states = 0;
        M1_PSEL = 1'b1; M1_PADDR = 8'h60;

        // Continuous tie: strict alternation starting with M0
        order = 4'b0000; n0 = 0; n1 = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge PCLK);
            if (S_PSEL && !S_PENABLE) order = {order[2:0], GRANT};
            n0 += int'(M0_PREADY);
            n1 += int'(M1_PREADY);
            check("t2_m0_pready", M0_PREADY, (c % 8) == 3);
            check("t2_m1_pready", M1_PREADY, (c % 8) == 7);
            if (c == 16) begin
                M0_PSEL = 1'b0; M1_PSEL = 1'b0;
            end
        end
        check("t2_grant_order", order, 4'b0101);
        check("t2_m0_count", n0, 2);
        check("t2_m1_count", n1, 2);
        @(negedge PCLK);
        check("t2_final_busy", BUSY, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_apb_rr_arbiter
`default_nettype wire
